// File: rtl/ifu_inst_queue.sv
// Decoupling FIFO between IFU and IDU. Each entry carries its PC, the raw
// instruction and a static branch prediction computed when it is written.

module ifu_iq_predecode (
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        taken_o,
  output logic [31:0] npc_o
);
  logic [31:0] imm_b;

  // Backward conditional branches (negative B-immediate) are predicted taken.
  assign taken_o = (inst_i[6:2] == 5'b11000) & inst_i[31];
  assign imm_b   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
  assign npc_o   = pc_i + (taken_o ? imm_b : 32'd4);
endmodule

module ifu_inst_queue #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jump_flush,
  input  logic          cs_flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_pred_taken,
  output logic [31:0]   out_pred_npc,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] pc_q, inst_q, npc_q;
  logic [DEPTH-1:0]       taken_q;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]            count_q, count_d;

  logic        flush, empty, push, pop;
  logic        pd_taken;
  logic [31:0] pd_npc;

  ifu_iq_predecode u_pd (
    .pc_i    (in_pc),
    .inst_i  (in_inst),
    .taken_o (pd_taken),
    .npc_o   (pd_npc)
  );

  assign flush     = jump_flush | cs_flush;
  assign empty     = (count_q == '0);
  // Fullness is judged on registered occupancy only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = reset & (count_q != FULL_CNT);
  assign out_valid = ~empty & ~flush;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign out_pc         = pc_q[rd_ptr_q];
  assign out_inst       = inst_q[rd_ptr_q];
  assign out_pred_taken = taken_q[rd_ptr_q];
  assign out_pred_npc   = npc_q[rd_ptr_q];
  assign count          = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      npc_q   <= '0;
      taken_q <= '0;
    end else if (push) begin
      pc_q[wr_ptr_q]    <= in_pc;
      inst_q[wr_ptr_q]  <= in_inst;
      npc_q[wr_ptr_q]   <= pd_npc;
      taken_q[wr_ptr_q] <= pd_taken;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (count_q <= FULL_CNT) else $error("ifu_inst_queue: count overflow");
      assert (!(pop && empty))     else $error("ifu_inst_queue: pop while empty");
    end
  end
endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed bench for ifu_inst_queue: cycle table plus hand-written sequences
// for wrap-around, flush and asynchronous reset.

module tb_ifu_inst_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        jump_flush = 1'b0, cs_flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;
  logic        in_ready, out_valid, out_pred_taken;
  logic [31:0] out_pc, out_inst, out_pred_npc;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ifu_inst_queue #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .jump_flush(jump_flush), .cs_flush(cs_flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_pred_taken(out_pred_taken),
    .out_pred_npc(out_pred_npc), .count(count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_cnt;
    logic        chk;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_tk;
    logic [31:0] e_npc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic ordy, logic e_ir, logic e_ov, logic [2:0] e_cnt,
                              logic chk, logic [31:0] e_pc, logic [31:0] e_inst,
                              logic e_tk, logic [31:0] e_npc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt; v.chk = chk;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_tk = e_tk; v.e_npc = e_npc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled shortly after.
  task automatic drive(logic iv, logic [31:0] pc, logic [31:0] inst, logic ordy,
                       logic jf, logic cf);
    @(negedge clock);
    in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    jump_flush = jf; cs_flush = cf;
    #2;
  endtask

  task automatic check_head(string tag, logic [31:0] pc, logic [31:0] inst,
                            logic tk, logic [31:0] npc);
    check({tag, ".out_pc"}, out_pc, pc);
    check({tag, ".out_inst"}, out_inst, inst);
    check({tag, ".pred_taken"}, 32'(out_pred_taken), 32'(tk));
    check({tag, ".pred_npc"}, out_pred_npc, npc);
  endtask

  logic [31:0] model_q[$];

  initial begin
    // basic push, branch pre-decode, fill/hold/drain, push+pop at count 3
    tv.push_back(mk(1, 32'h8000_0000, NOP, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h8000_0010, BEQ, 0, 1, 1, 1, 1, 32'h8000_0000, NOP, 0, 32'h8000_0004));
    tv.push_back(mk(1, 32'h0000_0000, BEQ, 1, 1, 1, 2, 1, 32'h8000_0000, NOP, 0, 32'h8000_0004));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 32'h8000_0010, BEQ, 1, 32'h8000_000C));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 32'h0000_0000, BEQ, 1, 32'hFFFF_FFFC));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h100, NOP, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h104, NOP, 0, 1, 1, 1, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(1, 32'h108, NOP, 0, 1, 1, 2, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(1, 32'h10C, NOP, 0, 1, 1, 3, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(1, 32'h110, NOP, 0, 0, 1, 4, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(1, 32'h110, NOP, 0, 0, 1, 4, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(1, 32'h110, NOP, 1, 0, 1, 4, 1, 32'h100, NOP, 0, 32'h104));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1, 32'h104, NOP, 0, 32'h108));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 32'h108, NOP, 0, 32'h10C));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 32'h10C, NOP, 0, 32'h110));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h200, NOP, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h204, NOP, 0, 1, 1, 1, 1, 32'h200, NOP, 0, 32'h204));
    tv.push_back(mk(1, 32'h208, NOP, 0, 1, 1, 2, 1, 32'h200, NOP, 0, 32'h204));
    tv.push_back(mk(1, 32'h20C, NOP, 1, 1, 1, 3, 1, 32'h200, NOP, 0, 32'h204));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 3, 1, 32'h204, NOP, 0, 32'h208));

    // reset held low for 3 cycles
    repeat (3) begin
      @(negedge clock); #2;
      check("rst.in_ready", 32'(in_ready), 0);
      check("rst.out_valid", 32'(out_valid), 0);
      check("rst.count", 32'(count), 0);
    end
    check("rst.out_pc", out_pc, 0);
    check("rst.pred_npc", out_pred_npc, 0);
    @(negedge clock); reset = 1'b1; #2;
    check("rel.in_ready", 32'(in_ready), 1);
    check("rel.out_valid", 32'(out_valid), 0);
    check("rel.count", 32'(count), 0);

    foreach (tv[i]) begin
      string t;
      t = $sformatf("tv%0d", i);
      drive(tv[i].iv, tv[i].pc, tv[i].inst, tv[i].ordy, 0, 0);
      check({t, ".in_ready"}, 32'(in_ready), 32'(tv[i].e_ir));
      check({t, ".out_valid"}, 32'(out_valid), 32'(tv[i].e_ov));
      check({t, ".count"}, 32'(count), 32'(tv[i].e_cnt));
      if (tv[i].chk) check_head(t, tv[i].e_pc, tv[i].e_inst, tv[i].e_tk, tv[i].e_npc);
    end

    // 10 concurrent push/pop at occupancy 3, crossing the pointer wrap
    model_q = '{32'h204, 32'h208, 32'h20C};
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc;
      pc = 32'h300 + 32'(4 * k);
      drive(1, pc, NOP, 1, 0, 0);
      check($sformatf("wrap%0d.count", k), 32'(count), 3);
      check($sformatf("wrap%0d.out_pc", k), out_pc, model_q[0]);
      check($sformatf("wrap%0d.pred_npc", k), out_pred_npc, model_q[0] + 32'd4);
      void'(model_q.pop_front());
      model_q.push_back(pc);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      check($sformatf("drain%0d.out_valid", k), 32'(out_valid), 1);
      check($sformatf("drain%0d.out_pc", k), out_pc, model_q[0]);
      void'(model_q.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0);
    check("drain.count", 32'(count), 0);

    // cs_flush at count 2 with a push and a pop both requested
    drive(1, 32'h400, NOP, 0, 0, 0);
    drive(1, 32'h404, NOP, 0, 0, 0);
    drive(1, 32'h408, NOP, 1, 0, 1);
    check("csf.out_valid", 32'(out_valid), 0);
    check("csf.count", 32'(count), 2);
    drive(0, 0, 0, 0, 0, 0);
    check("csf.count_next", 32'(count), 0);
    check("csf.out_valid_next", 32'(out_valid), 0);
    drive(1, 32'h500, BEQ, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("csf.count_after", 32'(count), 1);
    check_head("csf.head", 32'h500, BEQ, 1, 32'h4FC);

    // jump_flush masks the head at once and empties the queue next cycle
    drive(0, 0, 0, 1, 1, 0);
    check("jf.out_valid", 32'(out_valid), 0);
    drive(0, 0, 0, 0, 0, 0);
    check("jf.count", 32'(count), 0);

    // asynchronous reset in the middle of a burst
    drive(1, 32'h600, NOP, 0, 0, 0);
    drive(1, 32'h604, NOP, 0, 0, 0);
    check("arst.pre_count", 32'(count), 1);
    #1 reset = 1'b0;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.in_ready", 32'(in_ready), 0);
    check("arst.out_pc", out_pc, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1; #1;
    check("arst.rel_in_ready", 32'(in_ready), 1);
    drive(0, 0, 0, 0, 0, 0);
    check("arst.rel_count", 32'(count), 0);
    check("arst.rel_out_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
